conv3x3_window_gen: RTL and testbench
=====================================

// Module: conv3x3_window_gen
// PURPOSE
//  Producer side of the 3x3 conv feature interface. Takes a raster stream of GROUP_CHANNEL-channel
//  pixels and builds 3x3 windows with two row line-buffers. Emits windows packed in the exact
//  layout that the 3x3 16->4ch conv datapath consumes on its feature bus. Valid (no-padding)
//  windows only: (H-2)*(W-2) windows per frame.
// PARAMETERS
//  BITWIDTH       `BITWIDTH  bits per channel sample
//  GROUP_CHANNEL  16         channels per pixel
//  MAX_WIDTH      64         max frame width; line-buffer depth
//  BW_DIM         8          width of cfg_width/cfg_height and row/col counters
// PORTS
//  clk         in   1                           clock, all state on posedge
//  rst         in   1                           asynchronous, active-high reset
//  start       in   1                           1-cycle pulse: latch cfg, begin frame
//  cfg_width   in   BW_DIM                      frame width W, legal 3..MAX_WIDTH
//  cfg_height  in   BW_DIM                      frame height H, legal >=3
//  in_valid    in   1                           in_pixel valid
//  in_ready    out  1                           block accepts in_pixel
//  in_pixel    in   GROUP_CHANNEL*BITWIDTH      ch k at [(GROUP_CHANNEL-1-k)*BITWIDTH +: BITWIDTH]
//  out_valid   out  1                           window valid
//  out_ready   in   1                           downstream accepts window
//  feature     out  GROUP_CHANNEL*9*BITWIDTH    window; ch k, tap p at
//                                               [((GROUP_CHANNEL-1-k)*9+(8-p))*BITWIDTH +: BITWIDTH]
//  busy        out  1                           state != IDLE
//  frame_done  out  1                           1-cycle pulse on return to IDLE
//  cfg_err     out  1                           1-cycle pulse: start with illegal cfg
// BEHAVIOUR
//  - Reset: state=IDLE, row=col=0, in_ready=0, out_valid=0, feature=0, busy=0, frame_done=0,
//    cfg_err=0. Line-buffer contents are not reset.
//  - Tap p = 3*r+c. r=0 is the oldest row (y-2), c=0 is the oldest column (x-2).
//    Tap 8 is the newest pixel (y,x).
//  - FSM
//    IDLE:  start with legal cfg -> latch W,H; clear row/col; go to RUN.
//           start with illegal cfg -> cfg_err pulse; stay in IDLE.
//           start outside IDLE is ignored.
//    RUN:   accept pixels. After accepting (row=H-1, col=W-1), go to DRAIN.
//    DRAIN: wait until out_valid=0 or out_ready=1 -> IDLE, frame_done pulses that cycle.
//  - Handshake: in_ready = (state==RUN) & (~out_valid | out_ready).
//    A pixel is accepted on in_valid & in_ready.
//    out_valid/feature hold stable while out_valid & ~out_ready.
//  - On accept at column x:
//    - new column = {lb_top[x], lb_mid[x], in_pixel}.
//    - 3x3 window shifts one column toward older; the new column enters at c=2.
//    - lb_top[x] <= lb_mid[x]; lb_mid[x] <= in_pixel (read-before-write, same cycle).
//    - col wraps W-1 -> 0 with row+1.
//  - Output: an accept at row>=2 & col>=2 registers the updated window into feature and sets
//    out_valid the next cycle (latency 1). Otherwise out_valid clears on out_ready.
//  - Throughput: 1 pixel/clk with out_ready held high. Row starts need no bubbles; windows that
//    straddle rows are never emitted because of the col>=2 gate.
//  - A new frame may have a different W/H. Stale line-buffer data never reaches the output,
//    since the first window needs row>=2.
//  - Reset mid-frame: aborts immediately; no partial window is emitted after release.
//  - No arithmetic on samples; data is moved bit-exact.
// STRUCTURE
//  - Shared package/defines: BITWIDTH, GROUP_CHANNEL, FSM state localparams
//    (IDLE/RUN/DRAIN, 2-bit), tap-index function win_idx(k,p).
//  - Sub-module conv_line_buffer: MAX_WIDTH x GROUP_CHANNEL*BITWIDTH register array,
//    combinational read at addr, write enable at the same addr. Instantiated twice (top, mid).
//  - Top level holds the FSM, row/col counters, 3x3 window shift registers and output register.
// TESTING
//  1 W=4,H=3; pixel n has all channels = n -> 2 windows. First window ch0 taps p0..p8 =
//    0,1,2,4,5,6,8,9,10 (p0 at MSB of ch0 field). Second window = 1,2,3,5,6,7,9,10,11.
//    frame_done follows.
//  2 W=5,H=4, out_ready low 6 cycles mid-frame -> in_ready=0 and feature stable throughout.
//    Exactly 6 windows, in order, none lost or duplicated.
//  3 Random in_valid gaps and random out_ready, W=8,H=6 -> 24 windows bit-identical to a
//    golden model. Per-channel values are distinct (value = 16*n + k) to catch channel swaps.
//  4 start with cfg_width=2, then cfg_width=MAX_WIDTH+1 -> cfg_err pulses, busy=0, in_ready=0.
//    Then W=3,H=3 -> exactly 1 window.
//  5 rst asserted mid row 2 of W=6,H=5 -> all outputs at reset values immediately.
//    Next frame W=3,H=3 yields a correct single window, no stale window.
//  6 Back-to-back frames W=6 then W=3, start pulsed the cycle after frame_done
//    -> 4*... correct counts (W=6,H=4: 8 windows; W=3,H=5: 3 windows), no cross-frame mixing.

Source files
------------

// File: rtl/conv3x3_window_gen_pkg.sv
// Shared types and constants for the 3x3 window generator: sample geometry,
// FSM encoding and the feature-bus tap placement.
package conv3x3_window_gen_pkg;

  localparam int BITWIDTH      = 8;
  localparam int GROUP_CHANNEL = 16;
  localparam int PIX_W         = GROUP_CHANNEL * BITWIDTH;
  localparam int FEAT_W        = PIX_W * 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Bit offset of channel k, tap p on the feature bus (p0 of ch0 sits at the MSB end).
  function automatic int win_idx(input int k, input int p);
    return ((GROUP_CHANNEL - 1 - k) * 9 + (8 - p)) * BITWIDTH;
  endfunction

endpackage

// File: rtl/conv3x3_window_gen_line.sv
// One image-row line buffer: register array with combinational read and a
// same-address write, so a read-before-write swap happens in a single cycle.
module conv_line_buffer #(
  parameter int DEPTH = 64,
  parameter int DW    = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/conv3x3_window_gen.sv
// Raster pixel stream -> valid (unpadded) 3x3 windows packed for the 3x3 conv
// feature bus. Two line buffers supply the older rows of each new column.
module conv3x3_window_gen
  import conv3x3_window_gen_pkg::*;
#(
  parameter int MAX_WIDTH = 64,
  parameter int BW_DIM    = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [BW_DIM-1:0]                      cfg_width,
  input  logic [BW_DIM-1:0]                      cfg_height,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [GROUP_CHANNEL*BITWIDTH-1:0]      in_pixel,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [GROUP_CHANNEL*9*BITWIDTH-1:0]    feature,
  output logic                                   busy,
  output logic                                   frame_done,
  output logic                                   cfg_err
);

  localparam int AW = $clog2(MAX_WIDTH);
  localparam logic [BW_DIM-1:0] MAXW = BW_DIM'(MAX_WIDTH);

  state_e                        state_q, state_d;
  logic [BW_DIM-1:0]             w_q, w_d, h_q, h_d;
  logic [BW_DIM-1:0]             row_q, row_d, col_q, col_d;
  logic [2:0][2:0][PIX_W-1:0]    win_q, win_d;
  logic [FEAT_W-1:0]             feat_q, feat_d;
  logic                          out_valid_q, out_valid_d;
  logic                          cfg_err_q, cfg_err_d;
  logic                          accept, emit, cfg_ok;
  logic [PIX_W-1:0]              top_rd, mid_rd;

  assign in_ready = (state_q == RUN) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  // Column gate keeps windows that would straddle a row boundary off the bus.
  assign emit     = accept && (row_q >= BW_DIM'(2)) && (col_q >= BW_DIM'(2));
  assign cfg_ok   = (cfg_width >= BW_DIM'(3)) && (cfg_width <= MAXW) &&
                    (cfg_height >= BW_DIM'(3));

  conv_line_buffer #(.DEPTH(MAX_WIDTH), .DW(PIX_W), .AW(AW)) u_lb_top (
    .clk(clk), .we(accept), .addr(col_q[AW-1:0]), .wdata(mid_rd), .rdata(top_rd)
  );

  conv_line_buffer #(.DEPTH(MAX_WIDTH), .DW(PIX_W), .AW(AW)) u_lb_mid (
    .clk(clk), .we(accept), .addr(col_q[AW-1:0]), .wdata(in_pixel), .rdata(mid_rd)
  );

  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = top_rd;
      win_d[1][2] = mid_rd;
      win_d[2][2] = in_pixel;
    end
  end

  always_comb begin
    feat_d = feat_q;
    if (emit) begin
      for (int k = 0; k < GROUP_CHANNEL; k++) begin
        for (int p = 0; p < 9; p++) begin
          feat_d[win_idx(k, p) +: BITWIDTH] =
            win_d[p / 3][p % 3][(GROUP_CHANNEL - 1 - k) * BITWIDTH +: BITWIDTH];
        end
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    if (emit)           out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
  end

  always_comb begin
    state_d    = state_q;
    w_d        = w_q;
    h_d        = h_q;
    row_d      = row_q;
    col_d      = col_q;
    cfg_err_d  = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            w_d     = cfg_width;
            h_d     = cfg_height;
            row_d   = '0;
            col_d   = '0;
            state_d = RUN;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (accept) begin
          if (col_q == w_q - 1'b1) begin
            col_d = '0;
            row_d = row_q + 1'b1;
            if (row_q == h_q - 1'b1) state_d = DRAIN;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (!out_valid_q || out_ready) begin
          state_d    = IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      w_q         <= '0;
      h_q         <= '0;
      row_q       <= '0;
      col_q       <= '0;
      win_q       <= '0;
      feat_q      <= '0;
      out_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      h_q         <= h_d;
      row_q       <= row_d;
      col_q       <= col_d;
      win_q       <= win_d;
      feat_q      <= feat_d;
      out_valid_q <= out_valid_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign feature   = feat_q;
  assign busy      = (state_q != IDLE);
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_conv3x3_window_gen.sv
// Scoreboard bench for conv3x3_window_gen: a frame table plus hand-written
// reset-abort and back-to-back sequences, checked against an image-based model.
module tb_conv3x3_window_gen;

  localparam int G  = 16;
  localparam int B  = 8;
  localparam int PW = G * B;
  localparam int FW = PW * 9;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, in_ready, out_valid, out_ready;
  logic          busy, frame_done, cfg_err;
  logic [7:0]    cfg_width, cfg_height;
  logic [PW-1:0] in_pixel;
  logic [FW-1:0] feature;

  conv3x3_window_gen dut (
    .clk(clk), .rst(rst), .start(start), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_ready(out_ready), .feature(feature),
    .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int w; int h; bit mode; int base; int gap; int rdy; int stall_idx; int exp_win; bit exp_err;
  } frm_t;

  int            n_cmp = 0, n_err = 0;
  int            fd_cnt = 0, err_cnt = 0, stall_seen = 0;
  int            ready_pct = 100, stall_cycles = 0;
  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] seen[$];
  bit            prev_stall = 0;
  logic [FW-1:0] prev_feat;

  function automatic logic [B-1:0] pv(int n, int k, bit mode);
    int v;
    v = mode ? (16 * n + k) : n;
    return v[B-1:0];
  endfunction

  function automatic logic [PW-1:0] mkpix(int n, bit mode);
    logic [PW-1:0] p;
    for (int k = 0; k < G; k++) p[(G-1-k)*B +: B] = pv(n, k, mode);
    return p;
  endfunction

  function automatic logic [FW-1:0] mkwin(int base, int w, int y, int x, bit mode);
    logic [FW-1:0] f;
    for (int k = 0; k < G; k++)
      for (int p = 0; p < 9; p++)
        f[((G-1-k)*9 + (8-p))*B +: B] = pv(base + (y-2+p/3)*w + (x-2+p%3), k, mode);
    return f;
  endfunction

  task automatic chk(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_feat(string name, logic [FW-1:0] act, logic [FW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      int i;
      n_err++;
      i = 0;
      while (i < FW/B - 1 && act[i*B +: B] === exp[i*B +: B]) i++;
      $display("FAIL %s: byte %0d got %h want %h", name, i, act[i*B +: B], exp[i*B +: B]);
    end
  endtask

  // Output monitor: scoreboard pops, stall stability and stall back-pressure.
  initial forever begin
    @(negedge clk);
    if (rst) prev_stall = 0;
    else begin
      if (frame_done) fd_cnt++;
      if (cfg_err) err_cnt++;
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk_feat("hold_feature", feature, prev_feat);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL extra_window: got unexpected window want none");
        end else chk_feat("window", feature, exp_q.pop_front());
        seen.push_back(feature);
        prev_stall = 0;
      end else if (out_valid) begin
        chk("stall_in_ready", in_ready, 0);
        stall_seen++;
        prev_stall = 1;
        prev_feat  = feature;
      end else prev_stall = 0;
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (stall_cycles > 0) begin
        out_ready = 1'b0;
        stall_cycles--;
      end else out_ready = ($urandom_range(99) < ready_pct);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  task automatic run_frame(frm_t f, int abort_idx);
    int fd0, er0, tmo, idx;
    bit acc;
    seen.delete();
    fd0 = fd_cnt; er0 = err_cnt;
    ready_pct  = f.rdy;
    cfg_width  = 8'(f.w);
    cfg_height = 8'(f.h);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (f.exp_err) begin
      repeat (2) @(negedge clk);
      chk("cfg_err_pulse", err_cnt - er0, 1);
      chk("err_busy", busy, 0);
      chk("err_in_ready", in_ready, 0);
      return;
    end
    for (int y = 0; y < f.h; y++) begin
      for (int x = 0; x < f.w; x++) begin
        idx = y * f.w + x;
        if (f.gap > 0 && $urandom_range(99) < f.gap) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end
        if (idx == f.stall_idx) stall_cycles = 6;
        in_valid = 1'b1;
        in_pixel = mkpix(f.base + idx, f.mode);
        tmo = 0;
        do begin
          @(negedge clk);
          acc = in_ready;
          if (!acc) begin
            @(posedge clk); #1;
            tmo++;
          end
        end while (!acc && tmo < 200);
        if (!acc) begin
          n_cmp++; n_err++;
          $display("FAIL accept_timeout: got no in_ready want in_ready at pixel %0d", idx);
          in_valid = 1'b0;
          return;
        end
        if (y >= 2 && x >= 2) exp_q.push_back(mkwin(f.base, f.w, y, x, f.mode));
        @(posedge clk); #1;
        if (idx + 1 == abort_idx) begin
          in_valid = 1'b0;
          return;
        end
      end
    end
    in_valid = 1'b0;
    tmo = 0;
    do begin
      @(negedge clk);
      tmo++;
    end while (busy && tmo < 500);
    chk("drain_idle", busy, 0);
    chk("queue_empty", exp_q.size(), 0);
    chk("window_count", seen.size(), f.exp_win);
    chk("frame_done_count", fd_cnt - fd0, 1);
  endtask

  frm_t tbl[6];
  int   e0[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};

  initial begin
    logic [FW-1:0] f0;
    int st0;
    tbl[0] = '{w:4,  h:3, mode:0, base:0,   gap:0,  rdy:100, stall_idx:-1, exp_win:2,  exp_err:0};
    tbl[1] = '{w:5,  h:4, mode:1, base:100, gap:0,  rdy:100, stall_idx:13, exp_win:6,  exp_err:0};
    tbl[2] = '{w:8,  h:6, mode:1, base:300, gap:30, rdy:60,  stall_idx:-1, exp_win:24, exp_err:0};
    tbl[3] = '{w:2,  h:5, mode:1, base:0,   gap:0,  rdy:100, stall_idx:-1, exp_win:0,  exp_err:1};
    tbl[4] = '{w:65, h:5, mode:1, base:0,   gap:0,  rdy:100, stall_idx:-1, exp_win:0,  exp_err:1};
    tbl[5] = '{w:3,  h:3, mode:1, base:7,   gap:0,  rdy:100, stall_idx:-1, exp_win:1,  exp_err:0};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_pixel = '0;
    cfg_width = '0; cfg_height = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk_feat("rst_feature", feature, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      st0 = stall_seen;
      run_frame(tbl[i], -1);
      if (i == 1) chk("stall_cycles", stall_seen - st0, 6);
      if (i == 0) begin
        if (seen.size() >= 2) begin
          f0 = seen[0];
          for (int p = 0; p < 9; p++) chk("w0_ch0_tap", f0[((G-1)*9 + (8-p))*B +: B], e0[p]);
          f0 = seen[1];
          for (int p = 0; p < 9; p++) chk("w1_ch0_tap", f0[((G-1)*9 + (8-p))*B +: B], e0[p] + 1);
        end else begin
          n_cmp++; n_err++;
          $display("FAIL first_windows: got %0d windows want 2", seen.size());
        end
      end
    end

    // Reset in the middle of row 2, just after the first window of the frame was accepted.
    run_frame('{w:6, h:5, mode:1, base:500, gap:0, rdy:100, stall_idx:-1, exp_win:0, exp_err:0}, 15);
    rst = 1'b1;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_frame_done", frame_done, 0);
    chk_feat("abort_feature", feature, '0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_frame('{w:3, h:3, mode:1, base:900, gap:0, rdy:100, stall_idx:-1, exp_win:1, exp_err:0}, -1);

    // Back-to-back frames, second start right after the first frame returns to idle.
    run_frame('{w:6, h:4, mode:1, base:1000, gap:0, rdy:100, stall_idx:-1, exp_win:8, exp_err:0}, -1);
    run_frame('{w:3, h:5, mode:1, base:1200, gap:0, rdy:100, stall_idx:-1, exp_win:3, exp_err:0}, -1);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
